// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the pooling window engine:
//   - pool_mode_e : pooling mode (max or average)
//   - clog2       : ceiling log2 usable in constant expressions
//   - geometry_ok : window size / frame geometry sanity check
//   - is_pow2     : power-of-two test (average mode divides by shifting)
// No ports; imported by pool_combine and pool_window_engine.
// -----------------------------------------------------------------------------
package pool_pkg;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_AVG = 1'b1
  } pool_mode_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Windows tile the frame exactly and are at least 2x2.
  function automatic bit geometry_ok(input int k, input int w, input int h);
    if (k < 2) return 1'b0;
    return ((w % k) == 0) && ((h % k) == 0);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/pool_combine.sv
// -----------------------------------------------------------------------------
// pool_combine
// Per-channel fold used by the pooling engine. One instance per channel.
//   pixel  [DW] : incoming channel element
//   hacc   [AW] : running fold of the current window row
//   entry  [AW] : line-buffer partial result for this window column
//   first       : pixel opens a window row (kc == 0), fold restarts
//   load        : window is on its first row (kr == 0), entry is stale
//   avg         : 1 = fold is a sum, 0 = fold is a max
//   h_out  [AW] : new horizontal fold (hacc folded with pixel)
//   v_out  [AW] : new vertical fold (entry folded with h_out)
// Elements are widened to AW with sign or zero extension per SIGNED so the
// same datapath serves max and sum.
// -----------------------------------------------------------------------------
module pool_combine
  import pool_pkg::*;
#(
  parameter int DW     = 1,
  parameter int AW     = 1,
  parameter int SIGNED = 0
) (
  input  logic [DW-1:0] pixel,
  input  logic [AW-1:0] hacc,
  input  logic [AW-1:0] entry,
  input  logic          first,
  input  logic          load,
  input  logic          avg,
  output logic [AW-1:0] h_out,
  output logic [AW-1:0] v_out
);

  logic [AW-1:0] pix_ext;

  generate
    if (SIGNED != 0) begin : g_sext
      assign pix_ext = AW'($signed(pixel));
    end else begin : g_zext
      assign pix_ext = AW'(pixel);
    end
  endgenerate

  // Sum never overflows: AW carries log2(K*K) guard bits in average builds.
  function automatic logic [AW-1:0] fold(input logic [AW-1:0] a,
                                         input logic [AW-1:0] b,
                                         input logic          sum);
    if (sum) return a + b;
    if (SIGNED != 0) return ($signed(a) > $signed(b)) ? a : b;
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    h_out = first ? pix_ext : fold(hacc, pix_ext, avg);
    v_out = load ? h_out : fold(entry, h_out, avg);
  end

endmodule

// File: rtl/pool_window_engine.sv
// -----------------------------------------------------------------------------
// pool_window_engine
// Streaming KxK non-overlapping pooling over a raster-ordered frame.
// Build option: define POOL_AVG_EN to add average pooling (pool_avg = 1);
// without it the engine always max-pools and pool_avg is ignored.
// Ports:
//   clk            : clock, rising edge
//   reset          : asynchronous active-low reset
//   clear          : synchronous frame restart (drops a same-cycle pixel)
//   pool_avg       : average-mode request, sampled on the first frame pixel
//   stream_in      : one pixel, channel c at [c*DW +: DW]
//   stream_in_en   : stream_in valid this cycle
//   stream_out     : pooled pixel, same packing, held between pulses
//   stream_out_en  : one-cycle pulse marking a new stream_out
//   frame_done     : pulses with the last pooled pixel of a frame
// -----------------------------------------------------------------------------
module pool_window_engine
  import pool_pkg::*;
#(
  parameter int CH     = 128,
  parameter int DW     = 1,
  parameter int K      = 2,
  parameter int W_IN   = 32,
  parameter int H_IN   = 32,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             pool_avg,
  input  logic [CH*DW-1:0] stream_in,
  input  logic             stream_in_en,
  output logic [CH*DW-1:0] stream_out,
  output logic             stream_out_en,
  output logic             frame_done
);

  localparam int NWIN = W_IN / K;
  localparam int SH   = clog2(K * K);
`ifdef POOL_AVG_EN
  localparam int AW   = DW + SH;
`else
  localparam int AW   = DW;
`endif
  localparam int CW   = clog2(W_IN);
  localparam int RW   = clog2(H_IN);
  localparam int KW   = clog2(K);
  localparam int NW   = (clog2(NWIN) < 1) ? 1 : clog2(NWIN);

  localparam logic [CW-1:0] COL_LAST = CW'(W_IN - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H_IN - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(K - 1);

  generate
    if (!geometry_ok(K, W_IN, H_IN)) begin : g_bad_geometry
      $error("pool_window_engine: K must be >= 2 and divide W_IN and H_IN");
    end
`ifdef POOL_AVG_EN
    if (!is_pow2(K)) begin : g_bad_k
      $error("pool_window_engine: average pooling needs K a power of two");
    end
`endif
  endgenerate

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [KW-1:0]    kc;
  logic [KW-1:0]    kr;
  logic [NW-1:0]    win_col;
  logic [CH*AW-1:0] hacc;
  logic [CH*AW-1:0] h_all;
  logic [CH*AW-1:0] v_all;
  logic [CH*AW-1:0] entry_all;
  logic [CH*DW-1:0] result;
  logic             accept;
  logic             frame_start;
  logic             win_done;
  logic             avg;

  // Line buffer of per-window-column partial results; kr == 0 always
  // reloads an entry, so its contents never need a reset.
  logic [CH*AW-1:0] line_buf [NWIN];

  // A clear in the same cycle as a pixel discards that pixel.
  assign accept      = stream_in_en && !clear;
  assign frame_start = (col == '0) && (row == '0);
  assign win_done    = (kc == K_LAST) && (kr == K_LAST);
  assign entry_all   = line_buf[win_col];

`ifdef POOL_AVG_EN
  pool_mode_e mode_q;
  pool_mode_e mode_cur;

  // The mode is latched on the first pixel of a frame and that pixel already
  // uses the new mode; later pool_avg changes wait for the next frame.
  assign mode_cur = frame_start ? (pool_avg ? MODE_AVG : MODE_MAX) : mode_q;
  assign avg      = (mode_cur == MODE_AVG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_MAX;
    end else if (accept && frame_start) begin
      mode_q <= mode_cur;
    end
  end
`else
  logic unused_pool_avg;
  assign unused_pool_avg = pool_avg;
  assign avg             = 1'b0;
`endif

  // Raster position and in-window offsets; only accepted pixels advance them.
  // win_col tracks col / K so the line buffer index needs no divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col     <= '0;
      row     <= '0;
      kc      <= '0;
      kr      <= '0;
      win_col <= '0;
    end else if (clear) begin
      col     <= '0;
      row     <= '0;
      kc      <= '0;
      kr      <= '0;
      win_col <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col     <= '0;
        kc      <= '0;
        win_col <= '0;
        if (row == ROW_LAST) begin
          row <= '0;
          kr  <= '0;
        end else begin
          row <= row + 1'b1;
          kr  <= (kr == K_LAST) ? '0 : kr + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        if (kc == K_LAST) begin
          kc      <= '0;
          win_col <= win_col + 1'b1;
        end else begin
          kc <= kc + 1'b1;
        end
      end
    end
  end

  // Horizontal fold of the current window row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hacc <= '0;
    end else if (accept) begin
      hacc <= h_all;
    end
  end

  // Each completed window row is folded into its column's line-buffer entry.
  always_ff @(posedge clk) begin
    if (accept && (kc == K_LAST)) begin
      line_buf[win_col] <= v_all;
    end
  end

  generate
    for (genvar c = 0; c < CH; c++) begin : g_ch
      logic [AW-1:0] v_ch;

      pool_combine #(
        .DW     (DW),
        .AW     (AW),
        .SIGNED (SIGNED)
      ) u_combine (
        .pixel (stream_in[c*DW +: DW]),
        .hacc  (hacc[c*AW +: AW]),
        .entry (entry_all[c*AW +: AW]),
        .first (kc == '0),
        .load  (kr == '0),
        .avg   (avg),
        .h_out (h_all[c*AW +: AW]),
        .v_out (v_ch)
      );

      assign v_all[c*AW +: AW] = v_ch;

`ifdef POOL_AVG_EN
      logic [DW-1:0] avg_ch;
      // Divide by K*K with a truncating (flooring, when signed) shift.
      if (SIGNED != 0) begin : g_savg
        assign avg_ch = DW'($signed(v_ch) >>> SH);
      end else begin : g_uavg
        assign avg_ch = DW'(v_ch >> SH);
      end
      assign result[c*DW +: DW] = avg ? avg_ch : v_ch[DW-1:0];
`else
      assign result[c*DW +: DW] = v_ch;
`endif
    end
  endgenerate

  // Output register: loads on the pixel that closes a window, one-cycle
  // valid pulse, value held until the next window completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stream_out    <= '0;
      stream_out_en <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      stream_out_en <= 1'b0;
      frame_done    <= 1'b0;
      if (accept && win_done) begin
        stream_out    <= result;
        stream_out_en <= 1'b1;
        frame_done    <= (row == ROW_LAST) && (col == COL_LAST);
      end
    end
  end

endmodule

// File: tb/tb_pool_window_engine.sv
// -----------------------------------------------------------------------------
// tb_pool_window_engine
// Drives three engine configurations from one shared pixel stream:
//   u0 : CH=3, DW=8, K=2, 8x6 frame, signed
//   u1 : CH=3, DW=8, K=4, 8x8 frame, unsigned
//   u2 : CH=2, DW=1, K=2, 4x4 frame, binary
// A window-level reference model stores each frame's pixels and computes the
// pooled value of a window directly when its last pixel is issued; a monitor
// pops the expected values whenever an engine pulses stream_out_en.
// Average-mode scenarios are included when POOL_AVG_EN is defined.
// -----------------------------------------------------------------------------
module tb_pool_window_engine;

`ifdef POOL_AVG_EN
  localparam bit AVG_BUILD = 1'b1;
`else
  localparam bit AVG_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic [23:0] data;
    logic        done;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        pool_avg;
  logic        stream_in_en;
  logic [23:0] stream_in;
  logic [23:0] so0, so1;
  logic [1:0]  so2;
  logic        en0, en1, en2;
  logic        fd0, fd1, fd2;

  int cfg_ch  [3] = '{3, 3, 2};
  int cfg_dw  [3] = '{8, 8, 1};
  int cfg_k   [3] = '{2, 4, 2};
  int cfg_w   [3] = '{8, 8, 4};
  int cfg_h   [3] = '{6, 8, 4};
  int cfg_sgn [3] = '{1, 0, 0};

  logic [23:0] fr [3][64];
  int          m_row [3];
  int          m_col [3];
  bit          m_avg [3];
  exp_t        q0[$], q1[$], q2[$];

  int          checks;
  int          errors;
  int          pulse_cnt [3];
  int          done_cnt  [3];
  logic [23:0] first_out [3];

  pool_window_engine #(
    .CH(3), .DW(8), .K(2), .W_IN(8), .H_IN(6), .SIGNED(1)
  ) u0 (
    .clk(clk), .reset(reset), .clear(clear), .pool_avg(pool_avg),
    .stream_in(stream_in), .stream_in_en(stream_in_en),
    .stream_out(so0), .stream_out_en(en0), .frame_done(fd0)
  );

  pool_window_engine #(
    .CH(3), .DW(8), .K(4), .W_IN(8), .H_IN(8), .SIGNED(0)
  ) u1 (
    .clk(clk), .reset(reset), .clear(clear), .pool_avg(pool_avg),
    .stream_in(stream_in), .stream_in_en(stream_in_en),
    .stream_out(so1), .stream_out_en(en1), .frame_done(fd1)
  );

  pool_window_engine #(
    .CH(2), .DW(1), .K(2), .W_IN(4), .H_IN(4), .SIGNED(0)
  ) u2 (
    .clk(clk), .reset(reset), .clear(clear), .pool_avg(pool_avg),
    .stream_in(stream_in[1:0]), .stream_in_en(stream_in_en),
    .stream_out(so2), .stream_out_en(en2), .frame_done(fd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pooled value of the window whose bottom-right pixel is (r_end, c_end),
  // straight from the stored frame: max of the K*K elements, or their sum
  // divided by K*K with flooring, reduced to DW bits.
  function automatic logic [23:0] window_value(input int i, input int r_end,
                                               input int c_end, input bit avg);
    logic [23:0] res;
    int kk, dw, mask, sh;
    res  = '0;
    kk   = cfg_k[i];
    dw   = cfg_dw[i];
    mask = (1 << dw) - 1;
    sh   = 0;
    while ((1 << sh) < kk * kk) sh++;
    for (int c = 0; c < cfg_ch[i]; c++) begin
      int best, sum, v, outv;
      best = 0;
      sum  = 0;
      for (int r = r_end - kk + 1; r <= r_end; r++) begin
        for (int q = c_end - kk + 1; q <= c_end; q++) begin
          v = int'(fr[i][r * cfg_w[i] + q] >> (c * dw)) & mask;
          if (cfg_sgn[i] != 0 && v >= (1 << (dw - 1))) v = v - (1 << dw);
          sum = sum + v;
          if ((r == r_end - kk + 1 && q == c_end - kk + 1) || v > best) best = v;
        end
      end
      outv = avg ? (sum >>> sh) : best;
      res  = res | (24'(outv & mask) << (c * dw));
    end
    return res;
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push_exp(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic model_accept(input int i, input logic [23:0] px, input logic avg_in);
    int r, c;
    exp_t e;
    r = m_row[i];
    c = m_col[i];
    fr[i][r * cfg_w[i] + c] = px;
    if (r == 0 && c == 0) m_avg[i] = AVG_BUILD && avg_in;
    if ((r % cfg_k[i]) == cfg_k[i] - 1 && (c % cfg_k[i]) == cfg_k[i] - 1) begin
      e.data = window_value(i, r, c, m_avg[i]);
      e.done = (r == cfg_h[i] - 1) && (c == cfg_w[i] - 1);
      push_exp(i, e);
    end
    c++;
    if (c == cfg_w[i]) begin
      c = 0;
      r++;
      if (r == cfg_h[i]) r = 0;
    end
    m_row[i] = r;
    m_col[i] = c;
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_output(input int i, input logic en, input logic fd,
                              input logic [23:0] data);
    exp_t e;
    checks++;
    if (en !== 1'b1) begin
      if (en !== 1'b0 || fd !== 1'b0) begin
        errors++;
        $display("[TB] FAIL u%0d_idle: got en=%b done=%b, expected en=0 done=0", i, en, fd);
      end
      return;
    end
    if (qsize(i) == 0) begin
      errors++;
      $display("[TB] FAIL u%0d_unexpected_pulse: got data=%h, expected no pulse", i, data);
      return;
    end
    case (i)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    if (data !== e.data || fd !== e.done) begin
      errors++;
      $display("[TB] FAIL u%0d_window: got data=%h done=%b, expected data=%h done=%b",
               i, data, fd, e.data, e.done);
    end
    if (pulse_cnt[i] == 0) first_out[i] = data;
    pulse_cnt[i]++;
    if (fd === 1'b1) done_cnt[i]++;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check_output(0, en0, fd0, so0);
      check_output(1, en1, fd1, so1);
      check_output(2, en2, fd2, {22'b0, so2});
    end
  end

  // Drives one cycle of inputs and advances the reference model with it.
  task automatic apply_stimulus(input logic en, input logic clr,
                                input logic [23:0] px, input logic avg);
    @(posedge clk);
    #1;
    stream_in_en = en;
    clear        = clr;
    stream_in    = px;
    pool_avg     = avg;
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        m_row[i] = 0;
        m_col[i] = 0;
      end else if (en) begin
        model_accept(i, px, avg);
      end
    end
  endtask

  task automatic reset_counts();
    for (int i = 0; i < 3; i++) begin
      pulse_cnt[i] = 0;
      done_cnt[i]  = 0;
      first_out[i] = '0;
    end
  endtask

  task automatic drain(input string tag);
    repeat (4) apply_stimulus(1'b0, 1'b0, 24'h0, pool_avg);
    for (int i = 0; i < 3; i++) begin
      check_int($sformatf("%s_pending_u%0d", tag, i), qsize(i), 0);
    end
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once and
  // any window still in flight is discarded.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    stream_in_en = 1'b0;
    clear        = 1'b0;
    reset        = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    for (int i = 0; i < 3; i++) begin
      m_row[i] = 0;
      m_col[i] = 0;
    end
    #1;
    check_int({tag, "_u0"}, int'({so0, en0, fd0}), 0);
    check_int({tag, "_u1"}, int'({so1, en1, fd1}), 0);
    check_int({tag, "_u2"}, int'({so2, en2, fd2}), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [23:0] signed_px(input int n);
    case (n)
      0:       return 24'h0000FB;
      1:       return 24'h0000FD;
      8:       return 24'h000080;
      9:       return 24'h0000F9;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] avg_px(input int n);
    case (n)
      0:       return 24'd10;
      1:       return 24'd20;
      8:       return 24'd30;
      9:       return 24'd41;
      default: return 24'd0;
    endcase
  endfunction

  initial begin
    logic avg_v;
    bit   cleared;
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    clear        = 1'b0;
    pool_avg     = 1'b0;
    stream_in_en = 1'b0;
    stream_in    = '0;
    for (int i = 0; i < 3; i++) begin
      m_row[i] = 0;
      m_col[i] = 0;
      m_avg[i] = 1'b0;
    end
    reset_counts();

    #2 reset = 1'b0;
    #1;
    check_int("por_u0", int'({so0, en0, fd0}), 0);
    check_int("por_u1", int'({so1, en1, fd1}), 0);
    check_int("por_u2", int'({so2, en2, fd2}), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Binary frame: single 1 at (1,1) of the 4x4 engine.
    reset_counts();
    for (int n = 0; n < 16; n++) apply_stimulus(1'b1, 1'b0, (n == 5) ? 24'h1 : 24'h0, 1'b0);
    drain("binary");
    check_int("binary_pulses_u2", pulse_cnt[2], 4);
    check_int("binary_frame_done_u2", done_cnt[2], 1);
    check_int("binary_first_u2", int'(first_out[2]), 1);

    // Signed vs unsigned max over {-5,-3,-128,-7} / {FB,FD,80,F9}.
    do_reset("rst_a");
    reset_counts();
    for (int n = 0; n < 64; n++) apply_stimulus(1'b1, 1'b0, signed_px(n), 1'b0);
    drain("signed");
    check_int("signed_max_u0", int'(first_out[0][7:0]), 8'hFD);
    check_int("unsigned_max_u1", int'(first_out[1][7:0]), 8'hFD);
    check_int("frames_done_u1", done_cnt[1], 1);

`ifdef POOL_AVG_EN
    // Average of {10,20,30,41}; pool_avg toggles after the frame starts.
    do_reset("rst_avg");
    reset_counts();
    for (int n = 0; n < 48; n++) apply_stimulus(1'b1, 1'b0, avg_px(n), (n < 4) ? 1'b1 : n[0]);
    drain("avg");
    check_int("avg_u0", int'(first_out[0][7:0]), 25);
    check_int("avg_frame_u0", pulse_cnt[0], 12);
`endif

    // Random gapped stream with a clear at (3,5) of u0 and mode toggling.
    do_reset("rst_b");
    avg_v   = 1'b0;
    cleared = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) == 0) avg_v = ~avg_v;
      if (!cleared && m_row[0] == 3 && m_col[0] == 5) begin
        apply_stimulus(1'b1, 1'b1, 24'($urandom), avg_v);
        cleared = 1'b1;
      end else begin
        apply_stimulus(1'($urandom_range(0, 1)), 1'b0, 24'($urandom), avg_v);
      end
    end
    check_int("clear_applied", int'(cleared), 1);
    drain("gapped");

    // Back-to-back frames without gaps.
    reset_counts();
    for (int n = 0; n < 192; n++) begin
      if ($urandom_range(0, 19) == 0) avg_v = ~avg_v;
      apply_stimulus(1'b1, 1'b0, 24'($urandom), avg_v);
    end
    drain("gapfree");
    check_int("gapfree_pulses_u1", pulse_cnt[1], 12);
    check_int("gapfree_done_u0", done_cnt[0], 4);

    // Mid-frame reset, then the next pixel must start a fresh frame.
    for (int n = 0; n < 37; n++) apply_stimulus(1'b1, 1'b0, 24'($urandom), avg_v);
    do_reset("rst_mid");
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) avg_v = ~avg_v;
      apply_stimulus(1'($urandom_range(0, 1)), 1'b0, 24'($urandom), avg_v);
    end
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
